// File: rtl/hex_scan_pkg.sv
// Shared types and constants for the multiplexed hex display scanner.
package hex_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } scan_state_e;

    localparam int DIGIT_W    = 4;
    localparam int MAX_DIGITS = 8;

    localparam logic [MAX_DIGITS-1:0] ANODE_OFF = 8'hFF;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hex_scan_mux_scan_timer.sv
// Terminal-count timer shared by the lit and blanking periods of the scanner.
// A load restarts the count at zero and latches the last count value of the period.
module scan_timer #(
    parameter int CNT_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] last,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] last_r;

    // Count register: restart on load, saturate at the latched terminal value.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r  <= {CNT_W{1'b0}};
            last_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r  <= {CNT_W{1'b0}};
            last_r <= last;
        end else if (cnt_r != last_r) begin
            cnt_r  <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r  <= cnt_r;
        end
    end

    assign tc = (cnt_r == last_r);

endmodule

// File: rtl/hex_scan_mux.sv
// Time-multiplexed scanner for a common-anode 7-segment display with inter-digit blanking.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always lit).
module hex_scan_mux
    import hex_scan_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 100000,
    parameter int GAP_CYCLES = 2000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0]   data_in,
    output logic [DIGIT_W-1:0]              nibble,
    output logic [NUM_DIGITS-1:0]           an,
    output logic                            frame_tick
);

    localparam int DATA_W = DIGIT_W * NUM_DIGITS;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W  = $clog2(max_int(PRESCALE, GAP_CYCLES) + 1);

    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]      SHOW_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0]      GAP_LAST  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1)
                                                                   : {CNT_W{1'b0}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = ANODE_OFF[NUM_DIGITS-1:0];

    scan_state_e             state_r;
    scan_state_e             next_state_s;
    logic [IDX_W-1:0]        idx_r;
    logic [IDX_W-1:0]        idx_next_s;
    logic [IDX_W-1:0]        idx_adv_s;
    logic [IDX_W-1:0]        show_idx_s;
    logic [DATA_W-1:0]       data_r;
    logic [NUM_DIGITS-1:0]   an_r;
    logic [NUM_DIGITS-1:0]   an_next_s;
    logic [NUM_DIGITS-1:0]   slot_an_s;
    logic [NUM_DIGITS-1:0]   lit_an_s;
    logic [DIGIT_W-1:0]      nibble_r;
    logic [DIGIT_W-1:0]      nibble_next_s;
    logic [DIGIT_W-1:0]      adv_digit_s;
    logic                    tick_r;
    logic                    tick_next_s;
    logic                    tmr_load_s;
    logic [CNT_W-1:0]        tmr_last_s;
    logic                    tmr_tc_s;

    function automatic logic [DIGIT_W-1:0] digit_at(input logic [DATA_W-1:0] data,
                                                    input logic [IDX_W-1:0]  idx);
        logic [DIGIT_W-1:0] d;
        d = {DIGIT_W{1'b0}};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                d = data[i*DIGIT_W +: DIGIT_W];
            end
        end
        return d;
    endfunction

    scan_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (tmr_load_s),
        .last (tmr_last_s),
        .tc   (tmr_tc_s)
    );

    // Next index in scan order, wrapping after the leftmost digit.
    always_comb begin
        idx_adv_s = {IDX_W{1'b0}};
        if (idx_r == IDX_LAST) begin
            idx_adv_s = {IDX_W{1'b0}};
        end else begin
            idx_adv_s = idx_r + IDX_W'(1);
        end
    end

    // Index of the digit that the next SHOW entry will light.
    always_comb begin
        show_idx_s = {IDX_W{1'b0}};
        case (state_r)
            IDLE:    show_idx_s = {IDX_W{1'b0}};
            SHOW:    show_idx_s = idx_adv_s;
            GAP:     show_idx_s = idx_r;
            default: show_idx_s = {IDX_W{1'b0}};
        endcase
    end

    // One-cold anode pattern for the digit about to be lit.
    always_comb begin
        slot_an_s = AN_OFF;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (show_idx_s == IDX_W'(i)) begin
                slot_an_s[i] = 1'b0;
            end else begin
                slot_an_s[i] = 1'b1;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [DATA_W-1:0] show_data_s;
    logic              upper_nz_s;

    // Leading-zero test on the value held at SHOW entry (bypassing the write on a load from IDLE).
    always_comb begin
        show_data_s = data_r;
        upper_nz_s  = 1'b0;
        lit_an_s    = slot_an_s;
        if (state_r == IDLE) begin
            show_data_s = data_in;
        end else begin
            show_data_s = data_r;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((IDX_W'(i) >= show_idx_s) &&
                (show_data_s[i*DIGIT_W +: DIGIT_W] != 4'h0)) begin
                upper_nz_s = 1'b1;
            end
        end
        if ((show_idx_s != {IDX_W{1'b0}}) && !upper_nz_s) begin
            lit_an_s = AN_OFF;
        end else begin
            lit_an_s = slot_an_s;
        end
    end
`else
    assign lit_an_s = slot_an_s;
`endif

    assign adv_digit_s = digit_at(data_r, idx_adv_s);

    // Scan FSM: next state, index, timer control and next values of the output registers.
    always_comb begin
        next_state_s  = state_r;
        idx_next_s    = idx_r;
        an_next_s     = an_r;
        nibble_next_s = nibble_r;
        tick_next_s   = 1'b0;
        tmr_load_s    = 1'b0;
        tmr_last_s    = SHOW_LAST;
        case (state_r)
            IDLE: begin
                if (load) begin
                    next_state_s  = SHOW;
                    idx_next_s    = {IDX_W{1'b0}};
                    nibble_next_s = data_in[DIGIT_W-1:0];
                    an_next_s     = lit_an_s;
                    tmr_load_s    = 1'b1;
                    tmr_last_s    = SHOW_LAST;
                end else begin
                    an_next_s     = AN_OFF;
                    nibble_next_s = {DIGIT_W{1'b0}};
                end
            end
            SHOW: begin
                if (tmr_tc_s) begin
                    tick_next_s   = (idx_r == IDX_LAST);
                    idx_next_s    = idx_adv_s;
                    nibble_next_s = adv_digit_s;
                    tmr_load_s    = 1'b1;
                    if (GAP_CYCLES > 0) begin
                        next_state_s = GAP;
                        an_next_s    = AN_OFF;
                        tmr_last_s   = GAP_LAST;
                    end else begin
                        next_state_s = SHOW;
                        an_next_s    = lit_an_s;
                        tmr_last_s   = SHOW_LAST;
                    end
                end else begin
                    next_state_s = SHOW;
                end
            end
            GAP: begin
                if (tmr_tc_s) begin
                    next_state_s = SHOW;
                    an_next_s    = lit_an_s;
                    tmr_load_s   = 1'b1;
                    tmr_last_s   = SHOW_LAST;
                end else begin
                    next_state_s = GAP;
                end
            end
            default: begin
                next_state_s  = IDLE;
                idx_next_s    = {IDX_W{1'b0}};
                an_next_s     = AN_OFF;
                nibble_next_s = {DIGIT_W{1'b0}};
            end
        endcase
    end

    // State, index and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            idx_r    <= {IDX_W{1'b0}};
            an_r     <= AN_OFF;
            nibble_r <= {DIGIT_W{1'b0}};
            tick_r   <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            idx_r    <= idx_next_s;
            an_r     <= an_next_s;
            nibble_r <= nibble_next_s;
            tick_r   <= tick_next_s;
        end
    end

    // Held display value; a load never disturbs the digit currently lit.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r <= {DATA_W{1'b0}};
        end else if (load) begin
            data_r <= data_in;
        end else begin
            data_r <= data_r;
        end
    end

    assign an         = an_r;
    assign nibble     = nibble_r;
    assign frame_tick = tick_r;

endmodule

// File: tb/tb_hex_scan_mux.sv
// Directed bench for hex_scan_mux: cycle table on a gapped instance, hand sequence on a gapless one.
module tb_hex_scan_mux;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  nibble;
    logic [3:0]  an;
    logic        frame_tick;

    logic        rst0;
    logic        load0;
    logic [15:0] data0;
    logic [3:0]  nibble0;
    logic [3:0]  an0;
    logic        tick0;

    int checks;
    int errors;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [3:0] AN1_Z = 4'b1111;
    localparam logic [3:0] AN2_Z = 4'b1111;
    localparam logic [3:0] AN3_Z = 4'b1111;
`else
    localparam logic [3:0] AN1_Z = 4'b1101;
    localparam logic [3:0] AN2_Z = 4'b1011;
    localparam logic [3:0] AN3_Z = 4'b0111;
`endif

    typedef struct {
        logic        rst;
        logic        load;
        logic [15:0] data;
        int          reps;
        logic [3:0]  an;
        logic [3:0]  nib;
        logic        tick;
        logic        held_zero;
    } vec_t;

    vec_t vecs[$];

    hex_scan_mux #(
        .NUM_DIGITS (4),
        .PRESCALE   (4),
        .GAP_CYCLES (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .data_in    (data_in),
        .nibble     (nibble),
        .an         (an),
        .frame_tick (frame_tick)
    );

    hex_scan_mux #(
        .NUM_DIGITS (4),
        .PRESCALE   (4),
        .GAP_CYCLES (0)
    ) dut0 (
        .clk        (clk),
        .rst        (rst0),
        .load       (load0),
        .data_in    (data0),
        .nibble     (nibble0),
        .an         (an0),
        .frame_tick (tick0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic l, input logic [15:0] d, input int n,
                       input logic [3:0] a, input logic [3:0] nb, input logic t,
                       input logic hz);
        vec_t v;
        v.rst = r; v.load = l; v.data = d; v.reps = n;
        v.an = a; v.nib = nb; v.tick = t; v.held_zero = hz;
        vecs.push_back(v);
    endtask

    initial begin
        int         d;
        logic [3:0] exp_an;
        logic [3:0] exp_nib;
        logic       exp_tick;

        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        load    = 1'b0;
        data_in = 16'h0000;
        rst0    = 1'b1;
        load0   = 1'b0;
        data0   = 16'h0000;

        // reset, then idle
        add(1'b1, 1'b0, 16'h0000,  1, 4'b1111, 4'h0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 16'h0000, 20, 4'b1111, 4'h0, 1'b0, 1'b0);
        // first frame of 1234
        add(1'b0, 1'b1, 16'h1234,  1, 4'b1110, 4'h4, 1'b0, 1'b0);
        add(1'b0, 1'b0, 16'h0000,  3, 4'b1110, 4'h4, 1'b0, 1'b0);
        add(1'b0, 1'b0, 16'h0000,  1, 4'b1111, 4'h3, 1'b0, 1'b0);
        add(1'b0, 1'b0, 16'h0000,  4, 4'b1101, 4'h3, 1'b0, 1'b0);
        add(1'b0, 1'b0, 16'h0000,  1, 4'b1111, 4'h2, 1'b0, 1'b0);
        add(1'b0, 1'b0, 16'h0000,  4, 4'b1011, 4'h2, 1'b0, 1'b0);
        add(1'b0, 1'b0, 16'h0000,  1, 4'b1111, 4'h1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 16'h0000,  4, 4'b0111, 4'h1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 16'h0000,  1, 4'b1111, 4'h4, 1'b1, 1'b0);
        // second frame, ABCD loaded in 2nd cycle of digit-1 SHOW
        add(1'b0, 1'b0, 16'h0000,  4, 4'b1110, 4'h4, 1'b0, 1'b0);
        add(1'b0, 1'b0, 16'h0000,  1, 4'b1111, 4'h3, 1'b0, 1'b0);
        add(1'b0, 1'b0, 16'h0000,  2, 4'b1101, 4'h3, 1'b0, 1'b0);
        add(1'b0, 1'b1, 16'hABCD,  1, 4'b1101, 4'h3, 1'b0, 1'b0);
        add(1'b0, 1'b0, 16'h0000,  1, 4'b1101, 4'h3, 1'b0, 1'b0);
        add(1'b0, 1'b0, 16'h0000,  1, 4'b1111, 4'hB, 1'b0, 1'b0);
        add(1'b0, 1'b0, 16'h0000,  4, 4'b1011, 4'hB, 1'b0, 1'b0);
        add(1'b0, 1'b0, 16'h0000,  1, 4'b1111, 4'hA, 1'b0, 1'b0);
        add(1'b0, 1'b0, 16'h0000,  4, 4'b0111, 4'hA, 1'b0, 1'b0);
        add(1'b0, 1'b0, 16'h0000,  1, 4'b1111, 4'hD, 1'b1, 1'b0);
        add(1'b0, 1'b0, 16'h0000,  4, 4'b1110, 4'hD, 1'b0, 1'b0);
        add(1'b0, 1'b0, 16'h0000,  1, 4'b1111, 4'hC, 1'b0, 1'b0);
        add(1'b0, 1'b0, 16'h0000,  4, 4'b1101, 4'hC, 1'b0, 1'b0);
        add(1'b0, 1'b0, 16'h0000,  1, 4'b1111, 4'hB, 1'b0, 1'b0);
        add(1'b0, 1'b0, 16'h0000,  4, 4'b1011, 4'hB, 1'b0, 1'b0);
        add(1'b0, 1'b0, 16'h0000,  1, 4'b1111, 4'hA, 1'b0, 1'b0);
        add(1'b0, 1'b0, 16'h0000,  4, 4'b0111, 4'hA, 1'b0, 1'b0);
        add(1'b0, 1'b0, 16'h0000,  1, 4'b1111, 4'hD, 1'b1, 1'b0);
        // rst together with load during GAP, then restart
        add(1'b1, 1'b1, 16'h5678,  1, 4'b1111, 4'h0, 1'b0, 1'b1);
        add(1'b0, 1'b0, 16'h0000,  3, 4'b1111, 4'h0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 16'h5678,  1, 4'b1110, 4'h8, 1'b0, 1'b0);
        add(1'b0, 1'b0, 16'h0000,  3, 4'b1110, 4'h8, 1'b0, 1'b0);
        add(1'b0, 1'b0, 16'h0000,  1, 4'b1111, 4'h7, 1'b0, 1'b0);
        // leading-zero value 0070
        add(1'b1, 1'b0, 16'h0000,  1, 4'b1111, 4'h0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 16'h0070,  1, 4'b1110, 4'h0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 16'h0000,  3, 4'b1110, 4'h0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 16'h0000,  1, 4'b1111, 4'h7, 1'b0, 1'b0);
        add(1'b0, 1'b0, 16'h0000,  4, 4'b1101, 4'h7, 1'b0, 1'b0);
        add(1'b0, 1'b0, 16'h0000,  1, 4'b1111, 4'h0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 16'h0000,  4, AN2_Z,   4'h0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 16'h0000,  1, 4'b1111, 4'h0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 16'h0000,  4, AN3_Z,   4'h0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 16'h0000,  1, 4'b1111, 4'h0, 1'b1, 1'b0);
        // all-zero value
        add(1'b1, 1'b0, 16'h0000,  1, 4'b1111, 4'h0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 16'h0000,  1, 4'b1110, 4'h0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 16'h0000,  3, 4'b1110, 4'h0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 16'h0000,  1, 4'b1111, 4'h0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 16'h0000,  4, AN1_Z,   4'h0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 16'h0000,  1, 4'b1111, 4'h0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 16'h0000,  4, AN2_Z,   4'h0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 16'h0000,  1, 4'b1111, 4'h0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 16'h0000,  4, AN3_Z,   4'h0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 16'h0000,  1, 4'b1111, 4'h0, 1'b1, 1'b0);

        for (int k = 0; k < vecs.size(); k++) begin
            for (int r = 0; r < vecs[k].reps; r++) begin
                rst     = vecs[k].rst;
                load    = vecs[k].load;
                data_in = vecs[k].data;
                @(negedge clk);
                checks++;
                if (an !== vecs[k].an || nibble !== vecs[k].nib || frame_tick !== vecs[k].tick) begin
                    errors++;
                    $display("FAIL row%0d rep%0d: an=%b nibble=%h tick=%b, expected an=%b nibble=%h tick=%b",
                             k, r, an, nibble, frame_tick, vecs[k].an, vecs[k].nib, vecs[k].tick);
                end
                if (vecs[k].held_zero) begin
                    checks++;
                    if (dut.data_r !== 16'h0000) begin
                        errors++;
                        $display("FAIL held_after_rst: data=%h, expected 0000", dut.data_r);
                    end
                end
            end
        end
        rst  = 1'b0;
        load = 1'b0;

        // gapless instance: reset, then back-to-back digits of 1234
        @(negedge clk);
        checks++;
        if (an0 !== 4'b1111 || nibble0 !== 4'h0 || tick0 !== 1'b0) begin
            errors++;
            $display("FAIL gapless_reset: an=%b nibble=%h tick=%b, expected 1111 0 0", an0, nibble0, tick0);
        end
        rst0  = 1'b0;
        load0 = 1'b1;
        data0 = 16'h1234;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            load0    = 1'b0;
            d        = ((c - 1) / 4) % 4;
            exp_an   = ~(4'b0001 << d);
            exp_nib  = 4'(4 - d);
            exp_tick = (c > 1) && (((c - 1) % 16) == 0);
            checks++;
            if (an0 !== exp_an || nibble0 !== exp_nib || tick0 !== exp_tick) begin
                errors++;
                $display("FAIL gapless_c%0d: an=%b nibble=%h tick=%b, expected an=%b nibble=%h tick=%b",
                         c, an0, nibble0, tick0, exp_an, exp_nib, exp_tick);
            end
            checks++;
            if ($countones(~an0) != 1) begin
                errors++;
                $display("FAIL gapless_onehot_c%0d: an=%b, expected exactly one low bit", c, an0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
